// File: rtl/frame_pkg.sv
// frame_pkg: framing states and header constants shared by the frame arbiter.
package frame_pkg;
    typedef enum logic [2:0] {ARB, HDR1, HDR2, LEN, PAY, CS} state_t;
    localparam logic [7:0] HDR_BYTE0 = 8'hAA;
    localparam logic [7:0] HDR_BYTE1 = 8'h55;
    localparam int MAX_LEN = 255;
    localparam int LEN_W = $clog2(MAX_LEN + 1);
endpackage

// File: rtl/frame_rr_arbiter_rr.sv
// rr_arbiter: rotate-priority encoder; the first request after ptr_i wins.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [CH_W-1:0]   grant_o,
    output logic              any_req_o
);
    logic [CH_W-1:0] idx;
    // Walk the farthest candidate first so the nearest requester overwrites it.
    always_comb begin
        grant_o = ptr_i;
        idx = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = CH_W'((int'(ptr_i) + k) % NUM_CH);
            if (req_i[idx]) grant_o = idx;
        end
    end
    assign any_req_o = |req_i;
endmodule

// File: rtl/frame_rr_arbiter.sv
// frame_rr_arbiter: frame-atomic round-robin merge of NUM_CH byte streams.
// Define FRAME_TIMEOUT_EN to abort a grant stalled mid-frame for TIMEOUT_CYC cycles.
module frame_rr_arbiter
    import frame_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W = $clog2(NUM_CH),
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH*8-1:0] s_tdata,
    input  logic [NUM_CH-1:0]   s_tvalid,
    output logic [NUM_CH-1:0]   s_tready,
    output logic [7:0]          m_tdata,
    output logic                m_tvalid,
    output logic                m_tlast,
    output logic [CH_W-1:0]     m_tid,
    input  logic                m_tready,
    output logic                err_timeout
);
    state_t state_q, state_d;
    logic [CH_W-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, arb_grant;
    logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
    logic [7:0] in_byte, m_tdata_q;
    logic [CH_W-1:0] m_tid_q;
    logic m_tvalid_q, m_tlast_q, arb_any, go, xfer, last, abort;

    rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_rr (
        .req_i(s_tvalid),
        .ptr_i(rr_ptr_q),
        .grant_o(arb_grant),
        .any_req_o(arb_any)
    );

    assign go = (state_q != ARB) && (!m_tvalid_q || m_tready);
    assign s_tready = go ? (NUM_CH'(1) << grant_q) : '0;
    assign in_byte = s_tdata[{grant_q, 3'b000} +: 8];
    assign xfer = go && s_tvalid[grant_q];
    assign m_tdata = m_tdata_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tlast = m_tlast_q;
    assign m_tid = m_tid_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_ptr_d = rr_ptr_q;
        len_d = len_q;
        cnt_d = cnt_q;
        last = 1'b0;
        case (state_q)
            ARB: if (arb_any) begin
                grant_d = arb_grant;
                rr_ptr_d = arb_grant;
                state_d = HDR1;
            end
            HDR1: if (xfer) begin
                last = in_byte != HDR_BYTE0;
                state_d = last ? ARB : HDR2;
            end
            HDR2: if (xfer) begin
                last = in_byte != HDR_BYTE1;
                state_d = last ? ARB : LEN;
            end
            LEN: if (xfer) begin
                len_d = in_byte;
                cnt_d = '0;
                state_d = (in_byte == 8'd0) ? CS : PAY;
            end
            PAY: if (xfer) begin
                cnt_d = cnt_q + 1'b1;
                state_d = (cnt_d == len_q) ? CS : PAY;
            end
            CS: if (xfer) begin
                last = 1'b1;
                state_d = ARB;
            end
            default: state_d = ARB;
        endcase
        if (abort) state_d = ARB;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            grant_q <= '0;
            rr_ptr_q <= CH_W'(NUM_CH - 1);
            len_q <= '0;
            cnt_q <= '0;
            m_tdata_q <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q <= 1'b0;
            m_tid_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            len_q <= len_d;
            cnt_q <= cnt_d;
            if (xfer) begin
                m_tdata_q <= in_byte;
                m_tvalid_q <= 1'b1;
                m_tlast_q <= last;
                m_tid_q <= grant_q;
            end else if (m_tready) begin
                m_tvalid_q <= 1'b0;
            end
        end
    end

`ifdef FRAME_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYC + 1);
    logic [SW-1:0] stall_q;
    logic stalled, err_q;
    assign stalled = (state_q != ARB) && !s_tvalid[grant_q];
    assign abort = stalled && (stall_q == SW'(TIMEOUT_CYC - 1));
    assign err_timeout = err_q;
    // The counter holds while the source is valid but blocked downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            err_q <= 1'b0;
        end else begin
            stall_q <= (abort || xfer || state_q == ARB) ? '0 : stall_q + SW'(stalled);
            err_q <= abort;
        end
    end
`else
    assign abort = 1'b0;
    assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_frame_rr_arbiter.sv
// tb_frame_rr_arbiter: randomized self-checking bench with a per-channel frame model.
module tb_frame_rr_arbiter;
    localparam int NUM_CH = 4;
    localparam int CH_W = 2;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NUM_CH*8-1:0] s_tdata = '0;
    logic [NUM_CH-1:0] s_tvalid = '0;
    logic [NUM_CH-1:0] s_tready;
    logic [7:0] m_tdata;
    logic m_tvalid, m_tlast, err_timeout;
    logic m_tready = 1'b1;
    logic [CH_W-1:0] m_tid;

    frame_rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_tdata(s_tdata),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .m_tdata(m_tdata),
        .m_tvalid(m_tvalid),
        .m_tlast(m_tlast),
        .m_tid(m_tid),
        .m_tready(m_tready),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int tid;
        logic last;
        int cyc;
    } obs_t;

    logic [7:0] src_q [NUM_CH][$];
    logic [8:0] exp_q [NUM_CH][$];
    obs_t log_q [$];
    logic [NUM_CH-1:0] xfer_seen = '0;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int rdy_mode = 0;
    bit gaps = 1'b0;

    // Source driver: AXI-correct, holds valid until the byte is taken.
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < NUM_CH; c++) begin
            if (xfer_seen[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
            if (!(s_tvalid[c] && !xfer_seen[c])) begin
                s_tvalid[c] = src_q[c].size() > 0 && (!gaps || $urandom_range(3) != 0);
                s_tdata[c*8 +: 8] = src_q[c].size() > 0 ? src_q[c][0] : 8'h00;
            end
        end
        m_tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~m_tready : 1'($urandom_range(1));
    end

    initial forever begin
        @(negedge clk);
        xfer_seen = s_tvalid & s_tready;
        if (m_tvalid && m_tready) log_q.push_back('{m_tdata, int'(m_tid), m_tlast, cyc});
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        s_tvalid = '0;
        xfer_seen = '0;
        gaps = 1'b0;
        rdy_mode = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            src_q[c].delete();
            exp_q[c].delete();
        end
        log_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push(input int c, input logic [7:0] b, input logic last);
        src_q[c].push_back(b);
        exp_q[c].push_back({last, b});
    endtask

    task automatic send_good(input int c, input int len);
        push(c, 8'hAA, 1'b0);
        push(c, 8'h55, 1'b0);
        push(c, 8'(len), 1'b0);
        for (int i = 0; i < len; i++) push(c, 8'($urandom), 1'b0);
        push(c, 8'($urandom), 1'b1);
    endtask

    task automatic drain(input int budget);
        int n;
        bit busy;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            busy = m_tvalid;
            for (int c = 0; c < NUM_CH; c++) if (src_q[c].size() > 0) busy = 1'b1;
        end while (busy && n < budget);
        total++;
        if (busy) begin
            bad++;
            $display("FAIL drain: still busy after %0d cycles, required idle", n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        send_good(2, 6);
        repeat (5) @(negedge clk);
        total++;
        if (m_tvalid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid: got %b want 1", m_tvalid); end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
        total++;
        if (m_tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast: got %b want 0", m_tlast); end
        total++;
        if (m_tdata !== 8'h00) begin bad++; $display("FAIL rst_tdata: got %h want 00", m_tdata); end
        total++;
        if (m_tid !== '0) begin bad++; $display("FAIL rst_tid: got %0d want 0", m_tid); end
        total++;
        if (s_tready !== '0) begin bad++; $display("FAIL rst_tready: got %b want 0", s_tready); end
        total++;
        if (err_timeout !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err_timeout); end
        do_reset();
    endtask

    task automatic test_single();
        logic [7:0] fr [7];
        int vcyc, lat;
        fr = '{8'hAA, 8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 7; i++) push(1, fr[i], i == 6);
        vcyc = cyc + 1;
        drain(200);
        total++;
        if (log_q.size() != 7) begin bad++; $display("FAIL single_count: got %0d want 7", log_q.size()); end
        for (int i = 0; i < log_q.size() && i < 7; i++) begin
            total++;
            if (log_q[i].d !== fr[i] || log_q[i].tid != 1 || log_q[i].last !== (i == 6)) begin
                bad++;
                $display("FAIL single_byte%0d: got d=%h id=%0d last=%b want d=%h id=1 last=%b",
                         i, log_q[i].d, log_q[i].tid, log_q[i].last, fr[i], i == 6);
            end
        end
        lat = log_q.size() > 0 ? log_q[0].cyc - vcyc : -1;
        total++;
        if (lat != 2) begin bad++; $display("FAIL single_latency: got %0d want 2", lat); end
    endtask

    task automatic test_all4();
        int seg [$];
        int il;
        do_reset();
        @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) send_good(c, 1);
        send_good(0, 1);
        drain(500);
        il = 0;
        foreach (log_q[i]) begin
            if (log_q[i].last) seg.push_back(log_q[i].tid);
            if (i > 0 && !log_q[i-1].last && log_q[i].tid != log_q[i-1].tid) il++;
        end
        total++;
        if (log_q.size() != 25) begin bad++; $display("FAIL all4_count: got %0d want 25", log_q.size()); end
        total++;
        if (seg.size() != 5) begin bad++; $display("FAIL all4_frames: got %0d want 5", seg.size()); end
        for (int i = 0; i < seg.size() && i < 5; i++) begin
            total++;
            if (seg[i] != i % 4) begin bad++; $display("FAIL all4_order%0d: got ch%0d want ch%0d", i, seg[i], i % 4); end
        end
        total++;
        if (il != 0) begin bad++; $display("FAIL all4_interleave: got %0d switches want 0", il); end
    endtask

    task automatic test_len0();
        logic [7:0] fr [4];
        fr = '{8'hAA, 8'h55, 8'h00, 8'h5A};
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) push(3, fr[i], i == 3);
        drain(200);
        total++;
        if (log_q.size() != 4) begin bad++; $display("FAIL len0_count: got %0d want 4", log_q.size()); end
        for (int i = 0; i < log_q.size() && i < 4; i++) begin
            total++;
            if (log_q[i].d !== fr[i] || log_q[i].last !== (i == 3) || log_q[i].tid != 3) begin
                bad++;
                $display("FAIL len0_byte%0d: got d=%h last=%b id=%0d want d=%h last=%b id=3",
                         i, log_q[i].d, log_q[i].last, log_q[i].tid, fr[i], i == 3);
            end
        end
        @(negedge clk);
        send_good(3, 2);
        drain(200);
        total++;
        if (log_q.size() != 10 || log_q[9].last !== 1'b1) begin
            bad++;
            $display("FAIL len0_next: got count=%0d want 10 ending in last", log_q.size());
        end
    endtask

    task automatic test_bad_header();
        do_reset();
        @(negedge clk);
        push(2, 8'h12, 1'b1);
        send_good(3, 2);
        drain(200);
        total++;
        if (log_q.size() != 7) begin bad++; $display("FAIL badhdr_count: got %0d want 7", log_q.size()); end
        if (log_q.size() >= 2) begin
            total++;
            if (log_q[0].d !== 8'h12 || log_q[0].last !== 1'b1 || log_q[0].tid != 2) begin
                bad++;
                $display("FAIL badhdr_byte: got d=%h last=%b id=%0d want d=12 last=1 id=2",
                         log_q[0].d, log_q[0].last, log_q[0].tid);
            end
            total++;
            if (log_q[1].tid != 3) begin bad++; $display("FAIL badhdr_next: got ch%0d want ch3", log_q[1].tid); end
        end
        @(negedge clk);
        push(1, 8'hAA, 1'b0);
        push(1, 8'h13, 1'b1);
        drain(200);
        total++;
        if (log_q.size() != 9 || log_q[8].d !== 8'h13 || log_q[8].last !== 1'b1 || log_q[7].last !== 1'b0) begin
            bad++;
            $display("FAIL badhdr2: got count=%0d want 9 ending 13 with last", log_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic pv, pr, pl;
        logic [7:0] pd;
        logic [CH_W-1:0] pt;
        int stalls;
        do_reset();
        @(negedge clk);
        rdy_mode = 1;
        send_good(1, 8);
        pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0; pt = '0; stalls = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (pv && !pr) begin
                stalls++;
                total++;
                if (!m_tvalid || m_tdata !== pd || m_tid !== pt || m_tlast !== pl) begin
                    bad++;
                    $display("FAIL bp_hold: got v=%b d=%h last=%b want v=1 d=%h last=%b", m_tvalid, m_tdata, m_tlast, pd, pl);
                end
            end
            pv = m_tvalid; pr = m_tready; pd = m_tdata; pt = m_tid; pl = m_tlast;
            if (src_q[1].size() == 0 && !m_tvalid) break;
        end
        total++;
        if (stalls == 0) begin bad++; $display("FAIL bp_stalls: got 0 want >0"); end
        total++;
        if (log_q.size() != 12) begin bad++; $display("FAIL bp_count: got %0d want 12", log_q.size()); end
        for (int i = 0; i < log_q.size() && i < exp_q[1].size(); i++) begin
            total++;
            if ({log_q[i].last, log_q[i].d} !== exp_q[1][i]) begin
                bad++;
                $display("FAIL bp_byte%0d: got %h want %h", i, {log_q[i].last, log_q[i].d}, exp_q[1][i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic [8:0] e;
        int t, il, cur;
        bit open;
        do_reset();
        @(negedge clk);
        gaps = 1'b1;
        rdy_mode = 2;
        send_good(0, 255);
        for (int c = 0; c < NUM_CH; c++) begin
            for (int a = 0; a < 4; a++) begin
                b = 8'($urandom);
                case ($urandom_range(5))
                    0: push(c, b == 8'hAA ? 8'h3C : b, 1'b1);
                    1: begin push(c, 8'hAA, 1'b0); push(c, b == 8'h55 ? 8'hC3 : b, 1'b1); end
                    default: send_good(c, $urandom_range(20));
                endcase
            end
        end
        drain(20000);
        il = 0; open = 1'b0; cur = 0;
        foreach (log_q[i]) begin
            t = log_q[i].tid;
            if (open && t != cur) il++;
            open = !log_q[i].last;
            cur = t;
            total++;
            if (exp_q[t].size() == 0) begin
                bad++;
                $display("FAIL rand_extra: ch%0d got %h want nothing", t, log_q[i].d);
            end else begin
                e = exp_q[t].pop_front();
                if ({log_q[i].last, log_q[i].d} !== e) begin
                    bad++;
                    $display("FAIL rand_byte ch%0d: got %h want %h", t, {log_q[i].last, log_q[i].d}, e);
                end
            end
        end
        total++;
        if (il != 0) begin bad++; $display("FAIL rand_interleave: got %0d switches want 0", il); end
        for (int c = 0; c < NUM_CH; c++) begin
            total++;
            if (exp_q[c].size() != 0) begin bad++; $display("FAIL rand_missing ch%0d: got %0d left want 0", c, exp_q[c].size()); end
        end
    endtask

`ifdef FRAME_TIMEOUT_EN
    task automatic test_timeout();
        int err_cyc, pulses, lasts, gap;
        do_reset();
        @(negedge clk);
        push(0, 8'hAA, 1'b0);
        push(0, 8'h55, 1'b0);
        push(0, 8'h05, 1'b0);
        send_good(1, 1);
        err_cyc = -1; pulses = 0; lasts = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (err_timeout) begin
                pulses++;
                if (err_cyc < 0) err_cyc = cyc;
            end
        end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL to_pulses: got %0d want 1", pulses); end
        total++;
        if (log_q.size() != 8) begin bad++; $display("FAIL to_count: got %0d want 8", log_q.size()); end
        if (log_q.size() == 8) begin
            gap = err_cyc - log_q[2].cyc;
            total++;
            if (gap != TO) begin bad++; $display("FAIL to_delay: got %0d want %0d", gap, TO); end
            for (int i = 0; i < 3; i++) if (log_q[i].last || log_q[i].tid != 0) lasts++;
            total++;
            if (lasts != 0) begin bad++; $display("FAIL to_partial: got %0d bad bytes want 0", lasts); end
            total++;
            if (log_q[3].tid != 1 || log_q[7].tid != 1 || log_q[7].last !== 1'b1) begin
                bad++;
                $display("FAIL to_next: got ch%0d last=%b want ch1 last=1", log_q[3].tid, log_q[7].last);
            end
        end
    endtask
`else
    task automatic test_stall_hold();
        int errs;
        do_reset();
        @(negedge clk);
        push(0, 8'hAA, 1'b0);
        push(0, 8'h55, 1'b0);
        push(0, 8'h02, 1'b0);
        send_good(1, 1);
        errs = 0;
        repeat (40) begin
            @(negedge clk);
            if (err_timeout) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL hold_err: got %0d pulses want 0", errs); end
        total++;
        if (log_q.size() != 3) begin bad++; $display("FAIL hold_count: got %0d want 3", log_q.size()); end
        total++;
        if (s_tready !== 4'b0001) begin bad++; $display("FAIL hold_ready: got %b want 0001", s_tready); end
        push(0, 8'h77, 1'b0);
        push(0, 8'h66, 1'b0);
        push(0, 8'h99, 1'b1);
        drain(300);
        total++;
        if (log_q.size() != 11) begin bad++; $display("FAIL hold_total: got %0d want 11", log_q.size()); end
        if (log_q.size() == 11) begin
            total++;
            if (log_q[5].d !== 8'h99 || !log_q[5].last || log_q[5].tid != 0 || log_q[6].tid != 1) begin
                bad++;
                $display("FAIL hold_resume: got d=%h id=%0d next=ch%0d want d=99 id=0 next=ch1",
                         log_q[5].d, log_q[5].tid, log_q[6].tid);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_all4();
        test_len0();
        test_bad_header();
        test_backpressure();
        test_random();
`ifdef FRAME_TIMEOUT_EN
        test_timeout();
`else
        test_stall_hold();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
